rle_stream_encoder: RTL and testbench

- Parametrised, handshaked successor to the fixed 13-bit/8-bit run-length encoder in the DCT+RLE compression path.
- Takes one quantised DCT coefficient per accepted beat and emits (value, run-length) pairs.
- Adds valid/ready flow control on both sides, block-end flush via in_last, and run saturation at the counter maximum.
- Sits between the DCT quantiser output and the packing/storage stage.

---
 rtl/rle_pkg.sv | 17 +
 rtl/rle_out_reg.sv | 39 +++
 rtl/rle_stream_encoder.sv | 125 ++++++++++++
 tb/tb_rle_stream_encoder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared types and defaults for the run-length stream encoder.
package rle_pkg;

  localparam int RLE_DATA_W = 13;
  localparam int RLE_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } rle_state_e;

  function automatic int unsigned rle_max_run(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/rle_out_reg.sv
// Single valid/ready holding register for {data, count, last} pairs.
// "free" means a new pair may be loaded this cycle without losing the held one.
module rle_out_reg #(
  parameter int DATA_W = 13,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [CNT_W-1:0]  ld_cnt,
  input  logic              ld_last,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_last,
  output logic              out_valid,
  output logic              free
);

  assign free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= ld_data;
      out_count <= ld_cnt;
      out_last  <= ld_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rle_stream_encoder.sv
// Handshaked run-length encoder: coefficients in, (value, run-length, last) pairs out.
// Build option RLE_ZERO_ONLY_EN: only zero coefficients merge into runs.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no open run
// ST_RUN   | run_val/run_cnt hold an open run
// ST_FLUSH | closed last run waiting for the output register
module rle_stream_encoder
  import rle_pkg::*;
#(
  parameter int DATA_W = RLE_DATA_W,
  parameter int CNT_W  = RLE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [CNT_W-1:0] MAX_RUN = CNT_W'(rle_max_run(CNT_W));
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  rle_state_e        state, state_nxt;
  logic [DATA_W-1:0] run_val, run_val_nxt;
  logic [CNT_W-1:0]  run_cnt, run_cnt_nxt;
  logic              free, accept, same, match;
  logic              load, ld_last;
  logic [DATA_W-1:0] ld_data;
  logic [CNT_W-1:0]  ld_cnt;

  // Only accept when any pair this beat produces is guaranteed a free slot.
  assign in_ready = !rst && (state != ST_FLUSH) && free;
  assign accept   = in_valid && in_ready;

`ifdef RLE_ZERO_ONLY_EN
  assign same = (in_data == run_val) && (in_data == '0);
`else
  assign same = (in_data == run_val);
`endif
  assign match = same && (run_cnt != MAX_RUN);

  always_comb begin
    state_nxt   = state;
    run_val_nxt = run_val;
    run_cnt_nxt = run_cnt;
    load        = 1'b0;
    ld_data     = run_val;
    ld_cnt      = run_cnt;
    ld_last     = 1'b0;
    case (state)
      ST_IDLE: if (accept) begin
        if (in_last) begin
          load    = 1'b1;
          ld_data = in_data;
          ld_cnt  = ONE;
          ld_last = 1'b1;
        end else begin
          run_val_nxt = in_data;
          run_cnt_nxt = ONE;
          state_nxt   = ST_RUN;
        end
      end
      ST_RUN: if (accept) begin
        if (match) begin
          if (in_last) begin
            load      = 1'b1;
            ld_cnt    = run_cnt + ONE;
            ld_last   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            run_cnt_nxt = run_cnt + ONE;
          end
        end else begin
          // Close the current run; a last beat leaves its own run for FLUSH.
          load        = 1'b1;
          run_val_nxt = in_data;
          run_cnt_nxt = ONE;
          if (in_last) state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: if (free) begin
        load      = 1'b1;
        ld_last   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      run_val <= '0;
      run_cnt <= '0;
    end else begin
      state   <= state_nxt;
      run_val <= run_val_nxt;
      run_cnt <= run_cnt_nxt;
    end
  end

  rle_out_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .ld_data   (ld_data),
    .ld_cnt    (ld_cnt),
    .ld_last   (ld_last),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_last  (out_last),
    .out_valid (out_valid),
    .free      (free)
  );

endmodule

// File: tb/tb_rle_stream_encoder.sv
// Self-checking bench for rle_stream_encoder: directed scenarios plus randomized
// streams compared against a list-based run-length model.
module tb_rle_stream_encoder;

  localparam int DW   = 13;
  localparam int CW   = 8;
  localparam int MAXR = 255;
`ifdef RLE_ZERO_ONLY_EN
  localparam bit ZERO_ONLY = 1'b1;
`else
  localparam bit ZERO_ONLY = 1'b0;
`endif

  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
  typedef struct packed {logic [DW-1:0] d; logic [CW-1:0] c; logic l;} pair_t;

  logic          clk, rst;
  logic [DW-1:0] in_data;
  logic          in_valid, in_last, in_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic          out_last, out_valid, out_ready;

  int    checks = 0;
  int    errors = 0;
  int    stall_cnt = 0;
  bit    rand_rdy = 1'b0;
  int    gap_max = 0;
  beat_t stim[$];
  pair_t exp_q[$];
  pair_t got_q[$];
  bit    prev_stall = 1'b0;
  logic [DW+CW+1:0] prev_out;

  rle_stream_encoder #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: collects pairs and checks hold stability and ready gating.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if ({out_valid, out_data, out_count, out_last} !== prev_out) begin
          errors++;
          $display("FAIL hold_stable got %h required %h", {out_valid, out_data, out_count, out_last}, prev_out);
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_while_held in_ready %b required 0", in_ready);
        end
      end
      if (!in_ready) stall_cnt++;
      if (out_valid && out_ready) got_q.push_back({out_data, out_count, out_last});
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, out_data, out_count, out_last};
    end
  end

  task automatic add(input int v, input bit l);
    beat_t b;
    b.d = DW'(v);
    b.l = l;
    stim.push_back(b);
  endtask

  task automatic expp(input int v, input int c, input bit l);
    pair_t p;
    p.d = DW'(v);
    p.c = CW'(c);
    p.l = l;
    exp_q.push_back(p);
  endtask

  // Reference: split the beat list into maximal runs, capped at MAXR, closed at last.
  task automatic build_expected();
    logic [DW-1:0] cur;
    int cnt;
    bit have;
    have = 1'b0;
    cnt = 0;
    cur = '0;
    exp_q.delete();
    foreach (stim[i]) begin
      if (have && stim[i].d == cur && cnt < MAXR && (!ZERO_ONLY || stim[i].d == '0)) begin
        cnt++;
      end else begin
        if (have) exp_q.push_back({cur, CW'(cnt), 1'b0});
        cur = stim[i].d;
        cnt = 1;
        have = 1'b1;
      end
      if (stim[i].l) begin
        exp_q.push_back({cur, CW'(cnt), 1'b1});
        have = 1'b0;
      end
    end
  endtask

  task automatic run_stream();
    int n;
    foreach (stim[i]) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = stim[i].d;
      in_last  = stim[i].l;
      n = 0;
      forever begin
        @(negedge clk);
        if (in_ready || n > 100) break;
        n++;
      end
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout beat %0d in_ready 0 required 1", i);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input int want);
    int n;
    n = 0;
    while (got_q.size() < want && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b required 0", out_last); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b required 0", in_ready); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data got %h required 0", out_data); end
    checks++; if (out_count !== '0) begin errors++; $display("FAIL rst_out_count got %h required 0", out_count); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_bubble();
    got_q.delete(); stim.delete(); exp_q.delete();
    add(5, 0); add(5, 0); add(5, 0); add(-3, 1);
    expp(5, 3, 0); expp(-3, 1, 1);
    stall_cnt = 0;
    run_stream();
    drain(2);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL flush_npairs got %0d required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL flush_pair%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (stall_cnt != 1) begin errors++; $display("FAIL flush_bubble in_ready-low cycles %0d required 1", stall_cnt); end
  endtask

  task automatic test_saturation();
    got_q.delete(); stim.delete(); exp_q.delete();
    for (int i = 0; i < 300; i++) add(0, i == 299);
    expp(0, 255, 0); expp(0, 45, 1);
    run_stream();
    drain(2);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL sat_npairs got %0d required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL sat_pair%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_single();
    got_q.delete();
    in_valid = 1'b1; in_data = DW'(42); in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if ({out_valid, out_data, out_count, out_last} !== {1'b1, DW'(42), CW'(1), 1'b1}) begin
      errors++;
      $display("FAIL single_latency got v%b %0d/%0d/%b required v1 42/1/1", out_valid, out_data, out_count, out_last);
    end
    drain(1);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_npairs got %0d required 1", got_q.size()); end
    // A fresh run afterwards proves the FSM went back to idle.
    got_q.delete(); stim.delete(); exp_q.delete();
    add(42, 0); add(42, 1);
    expp(42, 2, 1);
    run_stream();
    drain(1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin errors++; $display("FAIL single_followup got %0d pairs first %h required 1 pair %h", got_q.size(), got_q[0], exp_q[0]); end
  endtask

  task automatic test_backpressure();
    int n;
    got_q.delete(); stim.delete(); exp_q.delete();
    add(7, 0); add(7, 0); add(8, 0); add(9, 1);
    expp(7, 2, 0); expp(8, 1, 0); expp(9, 1, 1);
    fork
      run_stream();
      begin
        n = 0;
        forever begin
          @(posedge clk); #1;
          n++;
          if (out_valid || n > 100) break;
        end
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain(3);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_npairs got %0d required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_pair%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_run();
    got_q.delete(); stim.delete();
    add(3, 0); add(3, 0); add(3, 0);
    run_stream();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b required 0", out_valid); end
    stim.delete(); exp_q.delete();
    add(1, 0); add(1, 1);
    expp(1, 2, 1);
    run_stream();
    drain(1);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL midrst_npairs got %0d required 1", got_q.size()); end
    checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL midrst_pair got %h required %h", got_q[0], exp_q[0]); end
  endtask

  task automatic test_zero_mode();
    got_q.delete(); stim.delete(); exp_q.delete();
    add(4, 0); add(4, 0); add(0, 0); add(0, 0); add(0, 1);
    if (ZERO_ONLY) begin
      expp(4, 1, 0); expp(4, 1, 0); expp(0, 3, 1);
    end else begin
      expp(4, 2, 0); expp(0, 3, 1);
    end
    run_stream();
    drain(exp_q.size());
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL zmode_npairs got %0d required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL zmode_pair%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int vals[4] = '{0, 0, 1, -1};
    int len;
    got_q.delete(); stim.delete();
    for (int b = 0; b < 6; b++) begin
      len = $urandom_range(1, 60);
      for (int i = 0; i < len; i++) add(vals[$urandom_range(0, 3)], i == len - 1);
    end
    for (int i = 0; i < 520; i++) add((i < 515) ? 9 : 0, i == 519);
    build_expected();
    gap_max = 2;
    rand_rdy = 1'b1;
    run_stream();
    drain(exp_q.size());
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    gap_max = 0;
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_npairs got %0d required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_pair%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_flush_bubble();
    test_saturation();
    test_single();
    test_backpressure();
    test_reset_mid_run();
    test_zero_mode();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
